operand_issue: RTL and testbench

OPERAND_ISSUE -- requirements
Module: operand_issue

---
 rtl/operand_issue.sv | 136 +++++++++++++
 tb/tb_operand_issue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/operand_issue.sv
// operand_issue: two-stage operand fetch / writeback wrapper around an
// external combinational 16-bit ALU.
//   Stage EX : operands latched at accept, driven on alu_* for one cycle.
//   Stage WB : result written to the 8x16 regfile, registered wb_* record.
// Optional feature macro: OPERAND_ISSUE_FWD_EN
//   defined   -> EX result is bypassed into the newly latched operands, so
//                there are never stall cycles.
//   undefined -> a read of the EX destination stalls issue for one cycle,
//                until the regfile holds the new value.
module operand_issue #(
  parameter int NREG = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_ld,
  input  logic [15:0] in_imm,
  input  logic [1:0]  in_op,
  input  logic [2:0]  in_rd,
  input  logic [2:0]  in_rs1,
  input  logic [2:0]  in_rs2,
  output logic [1:0]  alu_op,
  output logic [15:0] alu_i0,
  output logic [15:0] alu_i1,
  input  logic [15:0] alu_o,
  input  logic        alu_cout,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        carry
);

  logic [15:0] r_rf [NREG];

  // EX stage; operand/op registers are zeroed whenever EX is empty so the
  // ALU inputs rest at 0 during bubbles
  logic        r_ex_vld;
  logic        r_ex_ld;
  logic [1:0]  r_ex_op;
  logic [2:0]  r_ex_rd;
  logic [15:0] r_ex_a;
  logic [15:0] r_ex_b;
  logic [15:0] r_ex_imm;

  // WB record
  logic        r_wb_vld;
  logic [2:0]  r_wb_rd;
  logic [15:0] r_wb_data;
  logic        r_carry;

  logic        w_acc;
  logic        w_hz1;
  logic        w_hz2;
  logic [15:0] w_ex_res;
  logic [15:0] w_src1;
  logic [15:0] w_src2;

  // value the EX instruction will commit at the next edge
  assign w_ex_res = r_ex_ld ? r_ex_imm : alu_o;

  // source registers that collide with the EX destination
  assign w_hz1 = r_ex_vld && (in_rs1 == r_ex_rd);
  assign w_hz2 = r_ex_vld && (in_rs2 == r_ex_rd);

`ifdef OPERAND_ISSUE_FWD_EN
  assign in_ready = reset;
  assign w_src1   = w_hz1 ? w_ex_res : r_rf[in_rs1];
  assign w_src2   = w_hz2 ? w_ex_res : r_rf[in_rs2];
`else
  // hold the consumer for one cycle; the producer commits meanwhile and the
  // regfile read on the retry returns the new value
  assign in_ready = reset && !(in_valid && (w_hz1 || w_hz2));
  assign w_src1   = r_rf[in_rs1];
  assign w_src2   = r_rf[in_rs2];
`endif

  assign w_acc = in_valid && in_ready;

  assign alu_op   = r_ex_op;
  assign alu_i0   = r_ex_a;
  assign alu_i1   = r_ex_b;
  assign wb_valid = r_wb_vld;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign carry    = r_carry;

  // regfile: cleared on reset, written by the EX instruction as it retires
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (r_ex_vld) begin
      r_rf[r_ex_rd] <= w_ex_res;
    end
  end

  // EX stage: latch accepted instruction with its operands, else go empty
  always_ff @(posedge clk) begin
    if (!reset || !w_acc) begin
      r_ex_vld <= 1'b0;
      r_ex_ld  <= 1'b0;
      r_ex_op  <= '0;
      r_ex_rd  <= '0;
      r_ex_a   <= '0;
      r_ex_b   <= '0;
      r_ex_imm <= '0;
    end else begin
      r_ex_vld <= 1'b1;
      r_ex_ld  <= in_ld;
      r_ex_op  <= in_op;
      r_ex_rd  <= in_rd;
      r_ex_a   <= w_src1;
      r_ex_b   <= w_src2;
      r_ex_imm <= in_imm;
    end
  end

  // WB record: one-cycle valid pulse, rd/data hold between writes, carry
  // only follows ALU instructions
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wb_vld  <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_carry   <= 1'b0;
    end else begin
      r_wb_vld <= r_ex_vld;
      if (r_ex_vld) begin
        r_wb_rd   <= r_ex_rd;
        r_wb_data <= w_ex_res;
        if (!r_ex_ld) r_carry <= alu_cout;
      end
    end
  end

endmodule

// File: tb/tb_operand_issue.sv
// Scoreboard bench for operand_issue: the driver pushes hand-computed
// writeback records, a negedge monitor pops and compares each wb_valid pulse.
// The downstream ALU is modelled combinationally here (sub = a + ~b + 1, so
// carry=1 means no borrow; logic ops return carry 0).
module tb_operand_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_ld;
  logic [15:0] in_imm;
  logic [1:0]  in_op;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic [1:0]  alu_op;
  logic [15:0] alu_i0, alu_i1, alu_o;
  logic        alu_cout;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        carry;

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] data;
    logic        c;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND = 2'b10, OR = 2'b11;

  always #5 clk = ~clk;

  operand_issue #(.NREG(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ld(in_ld), .in_imm(in_imm), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .alu_op(alu_op), .alu_i0(alu_i0), .alu_i1(alu_i1),
    .alu_o(alu_o), .alu_cout(alu_cout),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .carry(carry)
  );

  function automatic logic [16:0] alu_f(input logic [1:0] op,
                                        input logic [15:0] a, input logic [15:0] b);
    case (op)
      ADD:     alu_f = {1'b0, a} + {1'b0, b};
      SUB:     alu_f = {1'b0, a} + {1'b0, ~b} + 17'd1;
      AND:     alu_f = {1'b0, a & b};
      default: alu_f = {1'b0, a | b};
    endcase
  endfunction

  assign {alu_cout, alu_o} = alu_f(alu_op, alu_i0, alu_i1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // monitor: every wb_valid pulse must match the oldest expected record
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h carry=%b, expected no writeback",
                 wb_rd, wb_data, carry);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data || carry !== e.c) begin
          fails++;
          $display("FAIL wb_record: got rd=%0d data=%h carry=%b, expected rd=%0d data=%h carry=%b",
                   wb_rd, wb_data, carry, e.rd, e.data, e.c);
        end
      end
    end
  end

  // Drive one instruction starting in the low clock phase; returns at the
  // negedge after acceptance with in_valid dropped.
  task automatic issue(input logic ld, input logic [1:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic [15:0] imm,
                       input logic [15:0] exp_d, input logic exp_c, input bit push,
                       output int stalls);
    logic rdy;
    in_valid = 1'b1; in_ld = ld; in_op = op; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    if (push) sb.push_back('{rd: rd, data: exp_d, c: exp_c});
    stalls = 0;
    forever begin
      #2 rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      stalls++;
      if (stalls > 20) begin
        tests++; fails++;
        $display("FAIL accept_timeout: rd=%0d never accepted, expected acceptance", rd);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic ld_i(input logic [2:0] rd, input logic [15:0] imm, input logic c_now);
    int s;
    issue(1'b1, ADD, rd, 3'd0, 3'd0, imm, imm, c_now, 1'b1, s);
  endtask

  task automatic alu_i(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [15:0] exp_d, input logic exp_c);
    int s;
    issue(1'b0, op, rd, rs1, rs2, 16'h0, exp_d, exp_c, 1'b1, s);
  endtask

  initial begin
    int st;
    int exp_stall;
    reset = 1'b0; in_valid = 1'b0; in_ld = 1'b0; in_imm = '0; in_op = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    @(negedge clk); @(negedge clk);
    // reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_wb", {11'd0, wb_valid, wb_rd, wb_data, carry}, 32'd0);
    check("rst_alu", {alu_op, alu_i0, alu_i1[13:0]}, 32'd0);
    reset = 1'b1;

    // load/load/add
    ld_i(3'd1, 16'h0005, 1'b0);
    ld_i(3'd2, 16'h0003, 1'b0);
    alu_i(ADD, 3'd3, 3'd1, 3'd2, 16'h0008, 1'b0);

    // add overflow and sub with both sources the same register
    ld_i(3'd1, 16'hFFFF, 1'b0);
    ld_i(3'd2, 16'h0001, 1'b0);
    alu_i(ADD, 3'd4, 3'd1, 3'd2, 16'h0000, 1'b1);
    alu_i(SUB, 3'd5, 3'd2, 3'd2, 16'h0000, 1'b1);

    // back-to-back dependency on both sources; load keeps carry=1
    ld_i(3'd1, 16'h00F0, 1'b1);
    issue(1'b0, OR, 3'd2, 3'd1, 3'd1, 16'h0, 16'h00F0, 1'b0, 1'b1, st);
`ifdef OPERAND_ISSUE_FWD_EN
    exp_stall = 0;
`else
    exp_stall = 1;
`endif
    check("dep_stall_cycles", st, exp_stall);

    // and: carry stays 0 across the and
    ld_i(3'd1, 16'h0F0F, 1'b0);
    ld_i(3'd2, 16'h00FF, 1'b0);
    alu_i(AND, 3'd6, 3'd1, 3'd2, 16'h000F, 1'b0);

    // idle: one drain cycle (wb pulse via monitor), then three quiet cycles
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_quiet", {7'd0, wb_valid, alu_op, alu_i0, alu_i1[5:0]}, 32'd0);
      check("idle_wb_hold", {12'd0, wb_rd, wb_data, carry}, {12'd0, 3'd6, 16'h000F, 1'b0});
    end

    // reset while an add sits in EX: it must never write back
    issue(1'b0, ADD, 3'd3, 3'd1, 3'd2, 16'h0, 16'h0, 1'b0, 1'b0, st);
    check("ex_alu_drive", {14'd0, alu_op, alu_i0}, {14'd0, ADD, 16'h0F0F});
    check("ex_alu_i1", {16'd0, alu_i1}, {16'd0, 16'h00FF});
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mid_wb", {11'd0, wb_valid, wb_rd, wb_data, carry}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_no_wb", {31'd0, wb_valid}, 32'd0);

    // every register reads 0 after reset
    alu_i(OR, 3'd7, 3'd1, 3'd2, 16'h0000, 1'b0);
    alu_i(OR, 3'd7, 3'd3, 3'd4, 16'h0000, 1'b0);
    alu_i(OR, 3'd7, 3'd5, 3'd6, 16'h0000, 1'b0);
    alu_i(ADD, 3'd0, 3'd7, 3'd0, 16'h0000, 1'b0);

    // drain with a bound
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("drain_pending", sb.size(), 32'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
